pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Hazard and stall sequencer for the 5-stage pipeline.
- Generates per-stage enable, flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Handles three cases: load-use hazards, taken-branch flushes, and multi-cycle data-memory waits (with timeout fault).
- Sits beside the pipeline registers; its outputs drive their enable/clear inputs directly.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive MEM_WAIT cycles before FAULT; legal range 1..255.
- CNT_W, 16: width of the stall performance counter.

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- ID_RS  in  5  rs field of the instruction in ID.
- ID_RT  in  5  rt field of the instruction in ID.
- EX_RT  in  5  destination (rt) of the instruction in EX.
- EX_MEM_READ  in  1  instruction in EX is a load.
- BRANCH_TAKEN  in  1  branch resolved taken in EX this cycle.
- MEM_REQ  in  1  instruction in MEM accesses data memory.
- MEM_READY  in  1  data memory completes the access this cycle.
- CNT_CLR  in  1  synchronous clear of STALL_CNT.
- PC_EN  out  1  PC register load enable.
- IF_ID_EN  out  1  IF/ID load enable.
- IF_ID_FLUSH  out  1  IF/ID loads NOP.
- ID_EX_EN  out  1  ID/EX load enable.
- ID_EX_FLUSH  out  1  ID/EX loads bubble (all control zero).
- EX_MEM_EN  out  1  EX/MEM load enable.
- MEM_WB_EN  out  1  MEM/WB load enable.
- MEM_WB_BUBBLE  out  1  MEM/WB loads zero control (no writeback).
- FAULT  out  1  sticky memory-timeout fault.
- STALL_CNT  out  CNT_W  count of cycles with PC_EN=0.

Behaviour:
- FSM states: RUN, MEM_WAIT, FAULT. Reset state is RUN.
- Internal registers:
  - WAIT_CNT, 8 bits, reset 0.
  - STALL_CNT, reset 0.
  - FAULT, reset 0.
- Control outputs are combinational from state and inputs, gated by RESET_N.
  - While RESET_N=0: all *_EN=0, all flushes=0, MEM_WB_BUBBLE=1.
- Definitions:
  - mem_busy = MEM_REQ & ~MEM_READY.
  - load_use = EX_MEM_READ & (EX_RT!=0) & ((EX_RT==ID_RS)|(EX_RT==ID_RT)).
- RUN state, conditions evaluated in priority order:
  1. mem_busy:
     - All *_EN=0, MEM_WB_BUBBLE=1, flushes=0.
     - Next state MEM_WAIT, WAIT_CNT<=1.
     - A branch or load-use seen in the same cycle is held and re-evaluated later; it is never lost.
  2. BRANCH_TAKEN:
     - All *_EN=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1.
     - Branch beats load-use, because the ID instruction is discarded.
  3. load_use:
     - PC_EN=0, IF_ID_EN=0, ID_EX_EN=1, ID_EX_FLUSH=1, EX_MEM_EN=1, MEM_WB_EN=1.
     - Exactly one bubble per load-use.
  4. Otherwise:
     - All *_EN=1, flushes=0, MEM_WB_BUBBLE=0.
- MEM_WAIT state:
  - MEM_READY=1:
    - Outputs identical to RUN evaluation with mem_busy=0, so branch and load-use apply this cycle.
    - Next state RUN, WAIT_CNT<=0.
  - MEM_READY=0 and WAIT_CNT<MEM_TIMEOUT:
    - Full freeze, as in RUN case 1.
    - WAIT_CNT increments.
  - MEM_READY=0 and WAIT_CNT==MEM_TIMEOUT:
    - Full freeze.
    - Next state FAULT, FAULT<=1.
- FAULT state:
  - All *_EN=0, MEM_WB_BUBBLE=1, flushes=0.
  - Exited only by reset; FAULT stays 1.
- STALL_CNT:
  - Increments on each clock edge where PC_EN=0 and RESET_N=1.
  - Saturates at all ones.
  - CNT_CLR=1 loads 0 and has priority over the increment.
- Reset mid-operation:
  - Async assertion returns the FSM to RUN immediately.
  - Clears WAIT_CNT, STALL_CNT and FAULT.
  - Outputs go to the reset values above in the same cycle.
- Latency:
  - Hazard controls are zero-cycle (combinational).
  - FSM transitions take one clock.

Optional Feature:
- Macro: PIPE_STALL_PERF_CNT_EN.
- Defined: STALL_CNT counter and CNT_CLR behave as described above.
- Undefined:
  - No counter flops are built.
  - STALL_CNT is tied to 0.
  - CNT_CLR is ignored.
  - All other behaviour is unchanged.

Test Plan:
- Load-use: EX_MEM_READ=1, EX_RT=5, ID_RS=5 for one cycle -> PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1 that cycle; STALL_CNT 0->1. Repeat with EX_RT=0 -> no stall.
- Branch over load-use: BRANCH_TAKEN=1 together with a load_use condition -> all EN=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1; STALL_CNT unchanged.
- Memory wait: MEM_REQ=1, MEM_READY=0 for 3 cycles, then MEM_READY=1 -> 3 freeze cycles with MEM_WB_BUBBLE=1 and STALL_CNT=3; on the ready cycle all EN=1 and state returns to RUN.
- Timeout: MEM_TIMEOUT=4, MEM_REQ=1, MEM_READY held 0 -> FAULT=1 after 5 frozen cycles; FAULT stays 1 after MEM_READY=1 and until RESET_N pulses low.
- Async reset mid-wait: drive RESET_N=0 between clock edges while in MEM_WAIT -> outputs go to reset values immediately; after release, state is RUN and STALL_CNT=0.
- Counter saturation and clear: CNT_W=4, hold load_use for 20 cycles -> STALL_CNT stops at 15; CNT_CLR=1 -> 0 next edge. With macro undefined -> STALL_CNT stays 0 throughout.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the hazard sequencer and the pipeline registers.
// The master side drives hazard inputs; the slave side (the sequencer) drives stage controls.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       ex_rt;
    logic             ex_mem_read;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             cnt_clr;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             mem_wb_bubble;
    logic             fault;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, ex_rt, ex_mem_read, branch_taken,
        output mem_req, mem_ready, cnt_clr,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        input  ex_mem_en, mem_wb_en, mem_wb_bubble, fault, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, ex_rt, ex_mem_read, branch_taken,
        input  mem_req, mem_ready, cnt_clr,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        output ex_mem_en, mem_wb_en, mem_wb_bubble, fault, stall_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Load-use / branch-flush / memory-wait stall sequencer for the 5-stage pipeline.
// Define PIPE_STALL_PERF_CNT_EN to build the stall performance counter.
module pipe_stall_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input logic               i_clk,
    input logic               i_rst_n,
    pipe_stall_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_nxt;
    logic       r_fault;
    logic       w_fault_nxt;

    logic w_mem_busy;
    logic w_load_use;
    logic w_run_eval;
    logic w_pc_en;
    logic w_if_id_en;
    logic w_if_id_flush;
    logic w_id_ex_en;
    logic w_id_ex_flush;
    logic w_ex_mem_en;
    logic w_mem_wb_en;
    logic w_mem_wb_bubble;

    assign w_mem_busy = bus.mem_req & ~bus.mem_ready;
    assign w_load_use = bus.ex_mem_read & (bus.ex_rt != 5'd0) &
                        ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 8'd0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wait_nxt      = r_wait_cnt;
        w_fault_nxt     = r_fault;
        w_run_eval      = 1'b0;
        w_pc_en         = 1'b0;
        w_if_id_en      = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_en      = 1'b0;
        w_id_ex_flush   = 1'b0;
        w_ex_mem_en     = 1'b0;
        w_mem_wb_en     = 1'b0;
        w_mem_wb_bubble = 1'b1;

        unique case (r_state)
            S_RUN: begin
                if (w_mem_busy) begin
                    w_state_nxt = S_WAIT;
                    w_wait_nxt  = 8'd1;
                end else begin
                    w_run_eval = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.mem_ready) begin
                    w_state_nxt = S_RUN;
                    w_wait_nxt  = 8'd0;
                    w_run_eval  = 1'b1;
                end else if (r_wait_cnt < 8'(MEM_TIMEOUT)) begin
                    w_wait_nxt = r_wait_cnt + 8'd1;
                end else begin
                    w_state_nxt = S_FAULT;
                    w_fault_nxt = 1'b1;
                end
            end
            S_FAULT: begin
                w_fault_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase

        // Branch outranks load-use: the ID instruction is discarded anyway.
        if (w_run_eval) begin
            w_mem_wb_bubble = 1'b0;
            w_id_ex_en      = 1'b1;
            w_ex_mem_en     = 1'b1;
            w_mem_wb_en     = 1'b1;
            priority case (1'b1)
                bus.branch_taken: begin
                    w_pc_en       = 1'b1;
                    w_if_id_en    = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end
                w_load_use: begin
                    w_id_ex_flush = 1'b1;
                end
                default: begin
                    w_pc_en    = 1'b1;
                    w_if_id_en = 1'b1;
                end
            endcase
        end
    end

    assign bus.pc_en         = i_rst_n & w_pc_en;
    assign bus.if_id_en      = i_rst_n & w_if_id_en;
    assign bus.if_id_flush   = i_rst_n & w_if_id_flush;
    assign bus.id_ex_en      = i_rst_n & w_id_ex_en;
    assign bus.id_ex_flush   = i_rst_n & w_id_ex_flush;
    assign bus.ex_mem_en     = i_rst_n & w_ex_mem_en;
    assign bus.mem_wb_en     = i_rst_n & w_mem_wb_en;
    assign bus.mem_wb_bubble = ~i_rst_n | w_mem_wb_bubble;
    assign bus.fault         = r_fault;

`ifdef PIPE_STALL_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = bus.cnt_clr;
    assign bus.stall_cnt    = '0;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed-vector bench for pipe_stall_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Counter expectations collapse to zero when PIPE_STALL_PERF_CNT_EN is undefined.
module tb_pipe_stall_ctrl;
    localparam int TMO = 4;
    localparam int CW  = 4;

    // {pc, if_id, if_id_fl, id_ex, id_ex_fl, ex_mem, mem_wb, wb_bubble}
    localparam logic [7:0] C_FRZ  = 8'b0000_0001;
    localparam logic [7:0] C_NORM = 8'b1101_0110;
    localparam logic [7:0] C_BR   = 8'b1111_1110;
    localparam logic [7:0] C_LU   = 8'b0001_1110;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;

    pipe_stall_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_stall_ctrl #(
        .MEM_TIMEOUT (TMO),
        .CNT_W       (CW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ctl();
        return {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en,
                bus.id_ex_flush, bus.ex_mem_en, bus.mem_wb_en,
                bus.mem_wb_bubble};
    endfunction

    function automatic logic [CW-1:0] exp_cnt(input int n);
        logic [CW-1:0] v;
        v = (n > 15) ? 4'd15 : 4'(n);
`ifndef PIPE_STALL_PERF_CNT_EN
        v = '0;
`endif
        return v;
    endfunction

    task automatic idle();
        bus.id_rs        = 5'd0;
        bus.id_rt        = 5'd0;
        bus.ex_rt        = 5'd0;
        bus.ex_mem_read  = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_ready    = 1'b0;
        bus.cnt_clr      = 1'b0;
    endtask

    task automatic clear_cnt();
        @(negedge clk);
        idle();
        bus.cnt_clr = 1'b1;
        @(negedge clk);
        bus.cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #1;
        nvec++;
        if (ctl() !== C_FRZ) begin
            nerr++;
            $display("FAIL reset_ctl got %b want %b", ctl(), C_FRZ);
        end
        nvec++;
        if (bus.fault !== 1'b0 || bus.stall_cnt !== 4'd0) begin
            nerr++;
            $display("FAIL reset_regs got fault=%b cnt=%0d want 0/0",
                     bus.fault, bus.stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nvec++;
        if (ctl() !== C_NORM) begin
            nerr++;
            $display("FAIL reset_release got %b want %b", ctl(), C_NORM);
        end
    endtask

    task automatic test_load_use();
        clear_cnt();
        bus.ex_mem_read = 1'b1;
        bus.ex_rt       = 5'd5;
        bus.id_rs       = 5'd5;
        #1;
        nvec++;
        if (ctl() !== C_LU) begin
            nerr++;
            $display("FAIL lu_rs got %b want %b", ctl(), C_LU);
        end
        @(negedge clk);
        idle();
        #1;
        nvec++;
        if (ctl() !== C_NORM || bus.stall_cnt !== exp_cnt(1)) begin
            nerr++;
            $display("FAIL lu_after got %b cnt=%0d want %b cnt=%0d",
                     ctl(), bus.stall_cnt, C_NORM, exp_cnt(1));
        end
        // EX_RT=0 never stalls even when it matches a source field
        bus.ex_mem_read = 1'b1;
        #1;
        nvec++;
        if (ctl() !== C_NORM) begin
            nerr++;
            $display("FAIL lu_r0 got %b want %b", ctl(), C_NORM);
        end
        @(negedge clk);
        bus.ex_rt = 5'd7;
        bus.id_rt = 5'd7;
        bus.id_rs = 5'd6;
        #1;
        nvec++;
        if (ctl() !== C_LU) begin
            nerr++;
            $display("FAIL lu_rt got %b want %b", ctl(), C_LU);
        end
        @(negedge clk);
        bus.id_rt = 5'd8;
        #1;
        nvec++;
        if (ctl() !== C_NORM) begin
            nerr++;
            $display("FAIL lu_nomatch got %b want %b", ctl(), C_NORM);
        end
        @(negedge clk);
        bus.ex_mem_read = 1'b0;
        bus.ex_rt       = 5'd7;
        bus.id_rt       = 5'd7;
        #1;
        nvec++;
        if (ctl() !== C_NORM || bus.stall_cnt !== exp_cnt(2)) begin
            nerr++;
            $display("FAIL lu_noload got %b cnt=%0d want %b cnt=%0d",
                     ctl(), bus.stall_cnt, C_NORM, exp_cnt(2));
        end
    endtask

    task automatic test_branch();
        clear_cnt();
        bus.branch_taken = 1'b1;
        bus.ex_mem_read  = 1'b1;
        bus.ex_rt        = 5'd9;
        bus.id_rs        = 5'd9;
        #1;
        nvec++;
        if (ctl() !== C_BR) begin
            nerr++;
            $display("FAIL br_over_lu got %b want %b", ctl(), C_BR);
        end
        @(negedge clk);
        idle();
        #1;
        nvec++;
        if (bus.stall_cnt !== exp_cnt(0)) begin
            nerr++;
            $display("FAIL br_cnt got %0d want %0d", bus.stall_cnt, exp_cnt(0));
        end
    endtask

    task automatic test_mem_wait();
        clear_cnt();
        bus.mem_req   = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        nvec++;
        if (ctl() !== C_NORM) begin
            nerr++;
            $display("FAIL mem_ready_now got %b want %b", ctl(), C_NORM);
        end
        @(negedge clk);
        bus.mem_ready    = 1'b0;
        bus.branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            nvec++;
            if (ctl() !== C_FRZ) begin
                nerr++;
                $display("FAIL mem_freeze%0d got %b want %b", i, ctl(), C_FRZ);
            end
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        #1;
        nvec++;
        if (ctl() !== C_BR) begin
            nerr++;
            $display("FAIL mem_ready_br got %b want %b", ctl(), C_BR);
        end
        @(negedge clk);
        idle();
        #1;
        nvec++;
        if (ctl() !== C_NORM || bus.stall_cnt !== exp_cnt(3) ||
            bus.fault !== 1'b0) begin
            nerr++;
            $display("FAIL mem_done got %b cnt=%0d f=%b want %b cnt=%0d f=0",
                     ctl(), bus.stall_cnt, bus.fault, C_NORM, exp_cnt(3));
        end
        // Load-use held through a one-cycle wait is applied on the ready cycle
        bus.mem_req     = 1'b1;
        bus.ex_mem_read = 1'b1;
        bus.ex_rt       = 5'd3;
        bus.id_rs       = 5'd3;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        nvec++;
        if (ctl() !== C_LU) begin
            nerr++;
            $display("FAIL mem_ready_lu got %b want %b", ctl(), C_LU);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_timeout();
        clear_cnt();
        bus.mem_req = 1'b1;
        for (int i = 0; i < TMO + 1; i++) begin
            #1;
            nvec++;
            if (ctl() !== C_FRZ || bus.fault !== 1'b0) begin
                nerr++;
                $display("FAIL tmo_cyc%0d got %b f=%b want %b f=0",
                         i, ctl(), bus.fault, C_FRZ);
            end
            @(negedge clk);
        end
        #1;
        nvec++;
        if (bus.fault !== 1'b1 || bus.stall_cnt !== exp_cnt(5)) begin
            nerr++;
            $display("FAIL tmo_fault got f=%b cnt=%0d want 1 cnt=%0d",
                     bus.fault, bus.stall_cnt, exp_cnt(5));
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        nvec++;
        if (ctl() !== C_FRZ || bus.fault !== 1'b1) begin
            nerr++;
            $display("FAIL tmo_sticky got %b f=%b want %b f=1",
                     ctl(), bus.fault, C_FRZ);
        end
        rst_n = 1'b0;
        #1;
        nvec++;
        if (bus.fault !== 1'b0 || bus.stall_cnt !== 4'd0) begin
            nerr++;
            $display("FAIL tmo_reset got f=%b cnt=%0d want 0/0",
                     bus.fault, bus.stall_cnt);
        end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        bus.mem_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if (ctl() !== C_FRZ || bus.stall_cnt !== 4'd0) begin
            nerr++;
            $display("FAIL midrst_ctl got %b cnt=%0d want %b cnt=0",
                     ctl(), bus.stall_cnt, C_FRZ);
        end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nvec++;
        if (ctl() !== C_NORM || bus.stall_cnt !== 4'd0) begin
            nerr++;
            $display("FAIL midrst_run got %b cnt=%0d want %b cnt=0",
                     ctl(), bus.stall_cnt, C_NORM);
        end
    endtask

    task automatic test_saturation();
        clear_cnt();
        bus.ex_mem_read = 1'b1;
        bus.ex_rt       = 5'd12;
        bus.id_rt       = 5'd12;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
        end
        #1;
        nvec++;
        if (bus.stall_cnt !== exp_cnt(20)) begin
            nerr++;
            $display("FAIL sat_cnt got %0d want %0d", bus.stall_cnt, exp_cnt(20));
        end
        bus.cnt_clr = 1'b1;
        @(negedge clk);
        #1;
        nvec++;
        if (bus.stall_cnt !== 4'd0) begin
            nerr++;
            $display("FAIL sat_clr got %0d want 0", bus.stall_cnt);
        end
        bus.cnt_clr = 1'b0;
        @(negedge clk);
        #1;
        nvec++;
        if (bus.stall_cnt !== exp_cnt(1)) begin
            nerr++;
            $display("FAIL sat_restart got %0d want %0d",
                     bus.stall_cnt, exp_cnt(1));
        end
        idle();
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
